window_buff: RTL

- Parametrised ROWS x COLS window buffer for the CNN datapath; sits between the main buffer and the PE/MAC array.
- Each write loads one full row from the main buffer.
- Each read streams the window out one element at a time over a valid/ready handshake.
- Supports row-major or column-major (transposed) read order, repeat streaming for filter reuse, and per-row load tracking.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/window_idx_gen.sv | 78 +++++++
 rtl/window_buff.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks: read-order encoding,
// window-buffer FSM states and the default element width.
package cnn_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // Read order of a window stream
    localparam logic ORDER_ROW = 1'b0;
    localparam logic ORDER_COL = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/window_idx_gen.sv
// 2-D (row, col) index generator for window streaming. Holds the index of the
// element currently in the output register, presents the following index
// combinationally (for the storage read), and flags the final element.
module window_idx_gen
    import cnn_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int COL_W = (COLS > 1) ? $clog2(COLS) : 1,
    parameter int IDX_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_i,
    input  logic             adv_i,
    input  logic             order_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] nrow_o,
    output logic [COL_W-1:0] ncol_o,
    output logic             last_o
);

    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [IDX_W-1:0] cnt_q;
    logic             order_q;
    logic             row_end;
    logic             col_end;

    assign row_end = (row_q == ROW_W'(ROWS - 1));
    assign col_end = (col_q == COL_W'(COLS - 1));
    assign last_o  = (cnt_q == IDX_W'(ROWS * COLS - 1));
    assign row_o   = row_q;
    assign col_o   = col_q;

    // Next index in the latched order; wraps to (0,0) after the last element
    always_comb begin
        nrow_o = row_q;
        ncol_o = col_q;
        if (order_q == ORDER_COL) begin
            if (row_end) begin
                nrow_o = '0;
                ncol_o = col_end ? '0 : col_q + COL_W'(1);
            end else begin
                nrow_o = row_q + ROW_W'(1);
            end
        end else begin
            if (col_end) begin
                ncol_o = '0;
                nrow_o = row_end ? '0 : row_q + ROW_W'(1);
            end else begin
                ncol_o = col_q + COL_W'(1);
            end
        end
    end

    // Index state: init restarts at (0,0) and latches the order, adv steps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            order_q <= ORDER_ROW;
        end else if (init_i) begin
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            order_q <= order_i;
        end else if (adv_i) begin
            row_q <= nrow_o;
            col_q <= ncol_o;
            cnt_q <= last_o ? '0 : cnt_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/window_buff.sv
// ROWS x COLS window buffer between the main buffer and the PE/MAC array.
// Rows are loaded whole; the window is streamed one element per handshake in
// row- or column-major order, optionally restreaming for filter reuse.
module window_buff
    import cnn_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int IDX_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
    parameter int COL_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ROW_W-1:0]       wr_row,
    input  logic [COLS*DATA_W-1:0] wr_data,
    input  logic                   clear,
    input  logic                   rd_start,
    input  logic                   col_major,
    input  logic                   repeat_en,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_last,
    output logic [ROW_W-1:0]       rd_row,
    output logic [COL_W-1:0]       rd_col,
    output logic                   busy,
    output logic [ROWS-1:0]        loaded,
    output logic                   start_err
);

    logic [DATA_W-1:0] mem_q [ROWS][COLS];
    logic [ROWS-1:0]   loaded_q, loaded_d;
    state_t            state_q, state_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              start_err_q, start_err_d;
    logic              wr_ok;
    logic              hs;
    logic              idx_init, idx_adv, idx_last;
    logic [ROW_W-1:0]  nrow;
    logic [COL_W-1:0]  ncol;

    assign wr_ok = wr_en && ({1'b0, wr_row} < (ROW_W + 1)'(ROWS));
    assign hs    = rd_valid_q & rd_ready;

    window_idx_gen #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk     (clk),
        .rst     (rst),
        .init_i  (idx_init),
        .adv_i   (idx_adv),
        .order_i (col_major),
        .row_o   (rd_row),
        .col_o   (rd_col),
        .nrow_o  (nrow),
        .ncol_o  (ncol),
        .last_o  (idx_last)
    );

    // Row storage; reads elsewhere see the pre-write contents of this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mem_q[r][c] <= '0;
        end else if (wr_ok) begin
            for (int c = 0; c < COLS; c++)
                mem_q[wr_row][c] <= wr_data[c*DATA_W +: DATA_W];
        end
    end

    // Loaded mask: clear first, then a same-cycle write sets its row
    always_comb begin
        loaded_d = clear ? '0 : loaded_q;
        if (wr_ok)
            loaded_d[wr_row] = 1'b1;
    end

    // Loaded mask register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) loaded_q <= '0;
        else     loaded_q <= loaded_d;
    end

    // FSM next state and output-register next values
    always_comb begin
        state_d     = state_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        start_err_d = 1'b0;
        idx_init    = 1'b0;
        idx_adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    if (&loaded_q) begin
                        state_d    = STREAM;
                        rd_valid_d = 1'b1;
                        rd_data_d  = mem_q[0][0];
                        idx_init   = 1'b1;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (hs) begin
                    idx_adv = 1'b1;
                    if (idx_last && !repeat_en) begin
                        state_d    = IDLE;
                        rd_valid_d = 1'b0;
                    end else begin
                        rd_data_d = mem_q[nrow][ncol];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            start_err_q <= start_err_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_valid_q & idx_last;
    assign busy      = (state_q == STREAM);
    assign loaded    = loaded_q;
    assign start_err = start_err_q;

endmodule
